// File: rtl/nes_joypad_port_if.sv
// Strobe/clock/data bus between the NES core and the joypad front-end.
// master = NES core side, slave = joypad port side.
interface nes_joypad_port_if;
  logic       i_joy_strobe;
  logic [1:0] i_joy_clock;
  logic [1:0] o_joy_data;

  modport master (output i_joy_strobe, output i_joy_clock, input  o_joy_data);
  modport slave  (input  i_joy_strobe, input  i_joy_clock, output o_joy_data);
endinterface

// File: rtl/nes_joypad_port.sv
// Two-player NES joypad front-end: board debounce, USB crossing, autofire and
// a 4021-style parallel-in/serial-out register per player, plus external pad pass-through.
module nes_joypad_port #(
  parameter int unsigned C_clk_hz        = 21477272,
  parameter int unsigned C_autofire_hz   = 10,
  parameter int unsigned C_debounce_bits = 16,
  parameter int unsigned C_fill_ones     = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               i_btn_board,
  input  logic [7:0]               i_btn_usb1,
  input  logic [7:0]               i_btn_usb2,
  input  logic [3:0]               i_turbo,
  input  logic                     i_ext_en,
  input  logic                     i_ext_data,
  nes_joypad_port_if.slave         joy,
  output logic                     o_ext_strobe,
  output logic                     o_ext_clock
);

  localparam int unsigned C_HALF = C_clk_hz / (2 * C_autofire_hz);
  localparam int unsigned C_AF_W = (C_HALF > 1) ? $clog2(C_HALF) : 1;
  localparam int unsigned C_DB_W = C_debounce_bits;

  logic [7:0]        r_board_s1, r_board_s2, r_board_deb;
  logic [C_DB_W-1:0] r_db_cnt;
  logic [7:0]        r_usb1_s1, r_usb1_s2, r_usb1_hold;
  logic [7:0]        r_usb2_s1, r_usb2_s2, r_usb2_hold;
  logic [C_AF_W-1:0] r_af_cnt;
  logic              r_af_phase;
  logic [1:0]        r_clk_prev;
  logic [7:0]        r_sr [2];
  logic [1:0]        r_joy_data;
  logic              r_ext_s1, r_ext_s2;
  logic              r_ext_strobe, r_ext_clock;

  logic [7:0]        w_p1, w_p2;
  logic [7:0]        w_eff [2];
  logic [1:0]        w_fall;

  // Board buttons: synchronise, then accept a new vector only after it is stable for a full counter sweep
  always_ff @(posedge clk) begin
    if (reset) begin
      r_board_s1  <= '0;
      r_board_s2  <= '0;
      r_board_deb <= '0;
      r_db_cnt    <= '0;
    end else begin
      r_board_s1 <= i_btn_board;
      r_board_s2 <= r_board_s1;
      if (r_board_s2 == r_board_deb) begin
        r_db_cnt <= '0;
      end else if (&r_db_cnt) begin
        r_board_deb <= r_board_s2;
        r_db_cnt    <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + C_DB_W'(1);
      end
    end
  end

  // USB vectors: hold register updates only when both sync stages agree, so all 8 bits move together
  always_ff @(posedge clk) begin
    if (reset) begin
      r_usb1_s1   <= '0;
      r_usb1_s2   <= '0;
      r_usb1_hold <= '0;
      r_usb2_s1   <= '0;
      r_usb2_s2   <= '0;
      r_usb2_hold <= '0;
    end else begin
      r_usb1_s1 <= i_btn_usb1;
      r_usb1_s2 <= r_usb1_s1;
      r_usb2_s1 <= i_btn_usb2;
      r_usb2_s2 <= r_usb2_s1;
      if (r_usb1_s1 == r_usb1_s2) r_usb1_hold <= r_usb1_s2;
      if (r_usb2_s1 == r_usb2_s2) r_usb2_hold <= r_usb2_s2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_af_cnt   <= '0;
      r_af_phase <= 1'b0;
    end else if (r_af_cnt == C_AF_W'(C_HALF - 1)) begin
      r_af_cnt   <= '0;
      r_af_phase <= ~r_af_phase;
    end else begin
      r_af_cnt <= r_af_cnt + C_AF_W'(1);
    end
  end

  // Autofire gates only A (bit 0) and B (bit 1)
  always_comb begin
    w_p1     = r_board_deb | r_usb1_hold;
    w_p2     = r_usb2_hold;
    w_eff[0] = {w_p1[7:2], w_p1[1] & (~i_turbo[1] | r_af_phase), w_p1[0] & (~i_turbo[0] | r_af_phase)};
    w_eff[1] = {w_p2[7:2], w_p2[1] & (~i_turbo[3] | r_af_phase), w_p2[0] & (~i_turbo[2] | r_af_phase)};
    w_fall   = r_clk_prev & ~joy.i_joy_clock;
  end

  // Strobe reloads every cycle and wins over a coincident falling edge
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clk_prev <= '0;
      r_sr[0]    <= '0;
      r_sr[1]    <= '0;
    end else begin
      r_clk_prev <= joy.i_joy_clock;
      for (int n = 0; n < 2; n++) begin
        if (joy.i_joy_strobe) begin
          r_sr[n] <= w_eff[n];
        end else if (w_fall[n]) begin
          r_sr[n] <= {1'(C_fill_ones), r_sr[n][7:1]};
        end
      end
    end
  end

  // External pad is active low; P1 register keeps running underneath while it is selected
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ext_s1     <= 1'b0;
      r_ext_s2     <= 1'b0;
      r_joy_data   <= '0;
      r_ext_strobe <= 1'b0;
      r_ext_clock  <= 1'b0;
    end else begin
      r_ext_s1      <= i_ext_data;
      r_ext_s2      <= r_ext_s1;
      r_joy_data[0] <= i_ext_en ? ~r_ext_s2 : r_sr[0][0];
      r_joy_data[1] <= r_sr[1][0];
      r_ext_strobe  <= joy.i_joy_strobe;
      r_ext_clock   <= joy.i_joy_clock[0];
    end
  end

  assign joy.o_joy_data = r_joy_data;
  assign o_ext_strobe   = r_ext_strobe;
  assign o_ext_clock    = r_ext_clock;

endmodule

// File: tb/tb_nes_joypad_port.sv
// Scoreboard bench for nes_joypad_port: two instances (fill ones / fill zeros) driven in parallel,
// expected serial bits derived from button vectors, autofire phase and read position.
module tb_nes_joypad_port;
  localparam int unsigned DB   = 4;
  localparam int unsigned HALF = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] board, usb1, usb2;
  logic [3:0] turbo;
  logic       ext_en, ext_data, strobe;
  logic [1:0] jclk;
  logic       ext_strobe0, ext_clock0, ext_strobe1, ext_clock1;

  nes_joypad_port_if jif0 ();
  nes_joypad_port_if jif1 ();
  assign jif0.i_joy_strobe = strobe;
  assign jif0.i_joy_clock  = jclk;
  assign jif1.i_joy_strobe = strobe;
  assign jif1.i_joy_clock  = jclk;

  nes_joypad_port #(.C_clk_hz(160), .C_autofire_hz(10), .C_debounce_bits(DB), .C_fill_ones(1)) u_dut (
    .clk(clk), .reset(reset), .i_btn_board(board), .i_btn_usb1(usb1), .i_btn_usb2(usb2),
    .i_turbo(turbo), .i_ext_en(ext_en), .i_ext_data(ext_data), .joy(jif0.slave),
    .o_ext_strobe(ext_strobe0), .o_ext_clock(ext_clock0));

  nes_joypad_port #(.C_clk_hz(160), .C_autofire_hz(10), .C_debounce_bits(DB), .C_fill_ones(0)) u_dut_fz (
    .clk(clk), .reset(reset), .i_btn_board(board), .i_btn_usb1(usb1), .i_btn_usb2(usb2),
    .i_turbo(turbo), .i_ext_en(ext_en), .i_ext_data(ext_data), .joy(jif1.slave),
    .o_ext_strobe(ext_strobe1), .o_ext_clock(ext_clock1));

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic [3:0]  val;   // {fz p2, fz p1, main p2, main p1}
    logic [3:0]  msk;
    string       name;
  } chk_t;

  chk_t        sb[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  int unsigned cyc    = 0;
  int unsigned rst_edge = 0;
  logic [7:0]  model_deb = 8'h00;
  logic [1:0]  exp_ext;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    exp_ext <= reset ? 2'b00 : {strobe, jclk[0]};
  end

  // Monitor: pop every scoreboard entry due this cycle and compare
  always @(negedge clk) begin
    chk_t       c;
    logic [3:0] obs;
    obs = {jif1.o_joy_data, jif0.o_joy_data};
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      c = sb.pop_front();
      n_chk++;
      if (c.cyc != cyc) begin
        n_fail++;
        $display("FAIL %s: check for cycle %0d reached at cycle %0d", c.name, c.cyc, cyc);
      end else if (((obs ^ c.val) & c.msk) != 4'b0000 || $isunknown(obs & c.msk)) begin
        n_fail++;
        $display("FAIL %s: got %b required %b (mask %b) at cycle %0d", c.name, obs, c.val, c.msk, cyc);
      end
    end
    if (cyc > 0) begin
      n_chk++;
      if ({ext_strobe0, ext_clock0} !== exp_ext || {ext_strobe1, ext_clock1} !== exp_ext) begin
        n_fail++;
        $display("FAIL ext_copy: got %b/%b required %b at cycle %0d",
                 {ext_strobe0, ext_clock0}, {ext_strobe1, ext_clock1}, exp_ext, cyc);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] eff(input logic [7:0] v, input logic ta, input logic tbb, input logic ph);
    eff = v;
    if (ta && !ph)  eff[0] = 1'b0;
    if (tbb && !ph) eff[1] = 1'b0;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int unsigned at, input logic [3:0] val, input logic [3:0] msk, input string name);
    chk_t c;
    c.cyc = at; c.val = val; c.msk = msk; c.name = name;
    sb.push_back(c);
  endtask

  task automatic do_reset();
    push(cyc + 1, 4'b0000, 4'b1111, "reset_out");
    push(cyc + 2, 4'b0000, 4'b1111, "reset_sr");
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    rst_edge = cyc;
  endtask

  task automatic set_board(input logic [7:0] v);
    board = v;
    tick(int'(2 ** DB) + 6);
    model_deb = v;
  endtask

  // Strobe for 3 cycles (optionally with a falling read clock inside), then nbits read pulses
  task automatic read(input int nbits, input bit prio, input string tag);
    int unsigned L;
    logic [7:0]  v1, v2;
    logic        ph, m1, m2, z1, z2;
    strobe = 1'b1;
    tick(1);
    if (prio) jclk = 2'b11;
    tick(1);
    jclk = 2'b00;
    tick(1);
    strobe = 1'b0;
    L  = cyc;
    ph = (((L - 1 - rst_edge) / HALF) % 2) == 1;
    v1 = eff(model_deb | usb1, turbo[0], turbo[1], ph);
    v2 = eff(usb2, turbo[2], turbo[3], ph);
    for (int k = 0; k < nbits; k++) begin
      m1 = (k < 8) ? v1[k] : 1'b1;
      m2 = (k < 8) ? v2[k] : 1'b1;
      z1 = (k < 8) ? v1[k] : 1'b0;
      z2 = (k < 8) ? v2[k] : 1'b0;
      if (ext_en) begin
        m1 = ~ext_data;
        z1 = ~ext_data;
      end
      push(L + 3 + 4 * k, {z2, z1, m2, m1}, 4'b1111, $sformatf("%s_bit%0d", tag, k));
    end
    tick(1);
    for (int k = 0; k < nbits; k++) begin
      jclk = 2'b11;
      tick(1);
      jclk = 2'b00;
      tick(3);
    end
  endtask

  initial begin
    int unsigned c;
    reset = 1'b0; board = '0; usb1 = '0; usb2 = '0; turbo = '0;
    ext_en = 1'b0; ext_data = 1'b1; strobe = 1'b0; jclk = 2'b00;
    do_reset();
    tick(3);

    // Debounce latency, observed through bit 0 while strobe is held
    strobe = 1'b1;
    tick(2);
    c = cyc;
    board = 8'h01;
    push(c + 19, 4'b0000, 4'b0101, "deb_early");
    push(c + 20, 4'b0101, 4'b0101, "deb_rise");
    tick(25);
    strobe = 1'b0;
    model_deb = 8'h01;
    tick(2);

    // Short glitch on bit 7 must be rejected
    board = 8'h81;
    tick(10);
    board = 8'h01;
    tick(25);
    read(8, 1'b0, "glitch");
    set_board(8'h00);

    // Serial read of A5 with 10 edges, then strobe priority with 02
    usb1 = 8'hA5; usb2 = 8'h3C;
    tick(5);
    read(10, 1'b0, "a5");
    usb1 = 8'h02;
    tick(5);
    read(10, 1'b1, "prio");

    // Autofire on player 2 A, then B with A turbo only
    usb1 = 8'h00; usb2 = 8'h01; turbo = 4'b0100;
    tick(5);
    for (int i = 0; i < 8; i++) begin
      read(1, 1'b0, "af_a");
      tick(int'($urandom_range(0, 9)));
    end
    usb2 = 8'h02;
    tick(5);
    for (int i = 0; i < 4; i++) begin
      read(2, 1'b0, "af_b");
      tick(int'($urandom_range(0, 9)));
    end

    // Randomised reads, with occasional board changes
    for (int i = 0; i < 12; i++) begin
      if (i % 4 == 3) set_board(8'($urandom));
      usb1  = 8'($urandom);
      usb2  = 8'($urandom);
      turbo = 4'($urandom);
      tick(5);
      read(10, 1'($urandom), "rnd");
      tick(int'($urandom_range(0, 7)));
    end
    turbo = '0;
    set_board(8'h00);

    // External pad on player 1
    ext_en = 1'b1;
    tick(5);
    c = cyc;
    ext_data = 1'b0;
    push(c + 2, 4'b0000, 4'b0101, "ext_lat");
    push(c + 3, 4'b0101, 4'b0101, "ext_press");
    tick(6);
    c = cyc;
    ext_data = 1'b1;
    push(c + 2, 4'b0101, 4'b0101, "ext_hold");
    push(c + 3, 4'b0000, 4'b0101, "ext_release");
    tick(6);
    usb1 = 8'hFF; usb2 = 8'h96;
    tick(5);
    read(10, 1'b0, "ext_read");
    ext_en = 1'b0;
    tick(3);

    // Reset in the middle of a read, then a clean reload
    usb1 = 8'hA5; usb2 = 8'h5A;
    tick(5);
    read(3, 1'b0, "pre_rst");
    do_reset();
    tick(5);
    read(10, 1'b0, "post_rst");

    tick(5);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d checks left in scoreboard, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
